// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP arithmetic set: field widths, constants,
// flag positions, divider FSM states and an operand unpack/classify helper.
package fp32_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int BIAS     = (1 << (FP_EXP_W - 1)) - 1;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    localparam int FLAG_W       = 4;
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_DIVZERO = 2;
    localparam int FLAG_OVERFLW = 1;
    localparam int FLAG_UNDRFLW = 0;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] expo;
        logic [FP_MAN_W-1:0] frac;
        fp_class_e           cls;
    } fp_unpacked_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } div_state_e;

    // Subnormals are flushed: a zero exponent field means zero regardless of fraction.
    function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] x);
        fp_unpacked_t u;
        u.sign = x[FP_W-1];
        u.expo = x[FP_W-2 -: FP_EXP_W];
        u.frac = x[FP_MAN_W-1:0];
        if (u.expo == '0)
            u.cls = FP_ZERO;
        else if (u.expo == '1)
            u.cls = (u.frac == '0) ? FP_INF : FP_NAN;
        else
            u.cls = FP_NORMAL;
        return u;
    endfunction

endpackage

// File: rtl/float32_division_if.sv
// Valid/ready operand and result bus shared by the FP arithmetic blocks.
interface float32_division_if
    import fp32_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   a;
    logic [FP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first, with a
// sticky bit that reports a nonzero final remainder.
module fp_mant_divider #(
    parameter int MANT_W = 24,
    parameter int ITER   = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [MANT_W-1:0] i_ma,
    input  logic [MANT_W-1:0] i_mb,
    output logic              o_last,
    output logic [ITER-1:0]   o_q,
    output logic              o_sticky
);

    localparam int CNT_W = $clog2(ITER);

    // Partial remainder stays below 2*divisor, so one extra bit is enough.
    logic [MANT_W:0]   r_rem;
    logic [MANT_W-1:0] r_div;
    logic [ITER-1:0]   r_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic              w_ge;
    logic [MANT_W:0]   w_diff;

    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= {1'b0, i_ma};
            r_div  <= i_mb;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= {w_diff[MANT_W-1:0], 1'b0};
            r_q   <= {r_q[ITER-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(ITER - 1))
                r_busy <= 1'b0;
        end
    end

    // High during the final iteration; q and sticky are complete from the next cycle.
    assign o_last   = r_busy & (r_cnt == CNT_W'(ITER - 1));
    assign o_q      = r_q;
    assign o_sticky = |r_rem;

endmodule

// File: rtl/float32_division.sv
// Iterative binary32 divider: special-case decode, restoring mantissa core,
// round-to-nearest-even and packing, with valid/ready on both sides.
module float32_division
    import fp32_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    float32_division_if.slave bus
);

    localparam int MANT_W   = MAN_W + 1;
    localparam int ITER     = MAN_W + 3;
    localparam int E_W      = EXP_W + 2;
    localparam int EXP_ALL1 = (1 << EXP_W) - 1;

    div_state_e              r_state, w_state_nxt;
    logic                    r_sign;
    logic signed [E_W-1:0]   r_exp;
    logic [FP_W-1:0]         r_result;
    logic [FLAG_W-1:0]       r_flags;
    logic                    r_out_valid;

    fp_unpacked_t            w_ua, w_ub;
    logic                    w_sign;
    logic                    w_in_ready, w_accept, w_div_start;
    logic                    w_special;
    logic [FP_W-1:0]         w_spec_result;
    logic [FLAG_W-1:0]       w_spec_flags;
    logic                    w_div_last, w_sticky;
    logic [ITER-1:0]         w_q;

    assign w_ua   = fp_unpack(bus.a);
    assign w_ub   = fp_unpack(bus.b);
    assign w_sign = w_ua.sign ^ w_ub.sign;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_special     = 1'b1;
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_ua.cls == FP_NAN || w_ub.cls == FP_NAN ||
            (w_ua.cls == FP_ZERO && w_ub.cls == FP_ZERO) ||
            (w_ua.cls == FP_INF && w_ub.cls == FP_INF)) begin
            w_spec_result               = QNAN;
            w_spec_flags[FLAG_INVALID]  = 1'b1;
        end else if (w_ub.cls == FP_ZERO && w_ua.cls == FP_NORMAL) begin
            w_spec_result               = {w_sign, POS_INF[FP_W-2:0]};
            w_spec_flags[FLAG_DIVZERO]  = 1'b1;
        end else if (w_ua.cls == FP_INF) begin
            w_spec_result = {w_sign, POS_INF[FP_W-2:0]};
        end else if (w_ub.cls == FP_INF || w_ua.cls == FP_ZERO) begin
            w_spec_result = {w_sign, {(FP_W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.in_valid) w_state_nxt = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (w_div_last) w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE:   if (r_out_valid && bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == S_IDLE);
        w_accept    = w_in_ready & bus.in_valid;
        w_div_start = w_accept & ~w_special;
    end

    fp_mant_divider #(.MANT_W(MANT_W), .ITER(ITER)) u_mant_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_div_start),
        .i_ma     ({1'b1, w_ua.frac}),
        .i_mb     ({1'b1, w_ub.frac}),
        .o_last   (w_div_last),
        .o_q      (w_q),
        .o_sticky (w_sticky)
    );

    logic [MANT_W-1:0]     w_man;
    logic [MANT_W:0]       w_man_rnd;
    logic [MAN_W-1:0]      w_frac;
    logic                  w_g, w_s, w_rnd;
    logic signed [E_W-1:0] w_e_norm, w_e_final;
    logic [FP_W-1:0]       w_norm_result;
    logic [FLAG_W-1:0]     w_norm_flags;

    // Quotient lies in (0.5, 2): either bit 25 or bit 24 is the leading one.
    always_comb begin
        if (w_q[ITER-1]) begin
            w_man    = w_q[ITER-1 -: MANT_W];
            w_g      = w_q[1];
            w_s      = w_q[0] | w_sticky;
            w_e_norm = r_exp;
        end else begin
            w_man    = w_q[ITER-2 -: MANT_W];
            w_g      = w_q[0];
            w_s      = w_sticky;
            w_e_norm = r_exp - E_W'(1);
        end
        w_rnd     = w_g & (w_s | w_man[0]);
        w_man_rnd = {1'b0, w_man} + (MANT_W + 1)'(w_rnd);
        w_e_final = w_man_rnd[MANT_W] ? (w_e_norm + E_W'(1)) : w_e_norm;
        w_frac    = w_man_rnd[MANT_W] ? w_man_rnd[MAN_W:1] : w_man_rnd[MAN_W-1:0];

        w_norm_flags = '0;
        if (int'(w_e_final) >= EXP_ALL1) begin
            w_norm_result              = {r_sign, POS_INF[FP_W-2:0]};
            w_norm_flags[FLAG_OVERFLW] = 1'b1;
        end else if (int'(w_e_final) <= 0) begin
            w_norm_result              = {r_sign, {(FP_W-1){1'b0}}};
            w_norm_flags[FLAG_UNDRFLW] = 1'b1;
        end else begin
            w_norm_result = {r_sign, w_e_final[EXP_W-1:0], w_frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= w_sign;
                r_exp  <= E_W'(w_ua.expo) - E_W'(w_ub.expo) + E_W'(BIAS);
                if (w_special) begin
                    r_result <= w_spec_result;
                    r_flags  <= w_spec_flags;
                end
            end
            if (r_state == S_NORM) begin
                r_result <= w_norm_result;
                r_flags  <= w_norm_flags;
            end
            // out_valid rises one cycle after DONE is entered and drops on transfer.
            if (r_state == S_DONE && !r_out_valid)
                r_out_valid <= 1'b1;
            else if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_float32_division.sv
// Directed bench for float32_division: normal quotients, specials, range limits,
// output backpressure and reset during an operation.
module tb_float32_division;

    localparam int LAT_LIMIT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    float32_division_if bus_if();

    float32_division dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Issue one operation; return result, flags and cycles from accept edge to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg, output int lat);
        @(negedge clk);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (bus_if.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus_if.result;
        flg = bus_if.flags;
    endtask

    task automatic consume();
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (bus_if.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
        end
        tests_run++;
        if (bus_if.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
        end
        tests_run++;
        if (bus_if.result !== 32'h0 || bus_if.flags !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h/%b expected 00000000/0000", bus_if.result, bus_if.flags);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input logic [3:0] exp_flg,
                                input int exp_lat);
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        run_op(a, b, res, flg, lat);
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (res !== exp_res) begin
            tests_failed++; $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        tests_run++;
        if (flg !== exp_flg) begin
            tests_failed++; $display("FAIL %s flags: got %b expected %b", name, flg, exp_flg);
        end
        consume();
    endtask

    task automatic test_normal();
        test_vectors("div_6_2",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28);
        test_vectors("div_1_3",  32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28);
        test_vectors("div_m8_2", 32'hC100_0000, 32'h4000_0000, 32'hC080_0000, 4'b0000, 28);
    endtask

    task automatic test_specials();
        test_vectors("one_by_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1);
        test_vectors("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1);
        test_vectors("m1_by_pzero",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 1);
        test_vectors("two_by_inf",   32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 1);
        test_vectors("nan_operand",  32'h7FC0_0001, 32'h4000_0000, 32'h7FC0_0000, 4'b1000, 1);
    endtask

    task automatic test_range();
        test_vectors("overflow",  32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0010, 28);
        test_vectors("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 28);
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          seen;
        run_op(32'h40C0_0000, 32'h4000_0000, res, flg, lat);
        tests_run++;
        if (lat !== 28 || res !== 32'h4040_0000) begin
            tests_failed++;
            $display("FAIL bp_first: got %h after %0d expected 40400000 after 28", res, lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                bus_if.a        = 32'h4040_0000;
                bus_if.b        = 32'h4080_0000;
                bus_if.in_valid = 1'b1;
            end
            tests_run++;
            if (bus_if.out_valid !== 1'b1 || bus_if.result !== 32'h4040_0000 || bus_if.flags !== 4'h0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b %h/%b expected v=1 40400000/0000",
                         i, bus_if.out_valid, bus_if.result, bus_if.flags);
            end
            tests_run++;
            if (bus_if.in_ready !== 1'b0) begin
                tests_failed++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus_if.in_ready);
            end
        end
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_transfer: got v=%b r=%b expected v=0 r=1", bus_if.out_valid, bus_if.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid === 1'b1 || bus_if.in_ready !== 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL bp_ignored_input: got %0d busy cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        bus_if.a        = 32'h40C0_0000;
        bus_if.b        = 32'h4000_0000;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_handshake: got r=%b v=%b expected r=1 v=0", bus_if.in_ready, bus_if.out_valid);
        end
        tests_run++;
        if (bus_if.result !== 32'h0 || bus_if.flags !== 4'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h/%b expected 00000000/0000", bus_if.result, bus_if.flags);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL midrst_no_result: got %0d valid cycles expected 0", seen);
        end
        test_vectors("div_3_4", 32'h4040_0000, 32'h4080_0000, 32'h3F40_0000, 4'b0000, 28);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
